// File: rtl/exhaustive_sweep_ctrl.sv
// Exhaustive input-sweep sequencer: applies every N_IN-bit vector, samples the unit output, scores it against EXP_TT.
// Optional macro SWEEP_GRAY_EN switches the application order from binary to reflected Gray code.
module exhaustive_sweep_ctrl #(
    parameter int unsigned           N_IN   = 3,
    parameter int unsigned           SETTLE = 2,
    parameter logic [(2**N_IN)-1:0]  EXP_TT = 8'hE8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);

    state_t          state_r, state_s;
    logic [N_IN-1:0] idx_r, idx_s;
    logic [7:0]      cnt_r, cnt_s;
    logic [N_IN-1:0] dut_in_r, dut_in_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            pass_r, pass_s;
    logic [N_IN:0]   err_cnt_r, err_cnt_s;
    logic [N_IN-1:0] first_fail_r, first_fail_s;
    logic            first_fail_vld_r, first_fail_vld_s;
    logic            mismatch_s;

    // Sweep position to applied vector; the index always counts in binary.
    function automatic logic [N_IN-1:0] idx_to_vec(input logic [N_IN-1:0] idx);
`ifdef SWEEP_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    assign mismatch_s = (dut_out != EXP_TT[dut_in_r]);

    // Next-state and next-output logic of the sweep FSM.
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        cnt_s            = cnt_r;
        dut_in_s         = dut_in_r;
        busy_s           = 1'b0;
        done_s           = 1'b0;
        pass_s           = pass_r;
        err_cnt_s        = err_cnt_r;
        first_fail_s     = first_fail_r;
        first_fail_vld_s = first_fail_vld_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s          = ST_SETTLE;
                    idx_s            = {N_IN{1'b0}};
                    cnt_s            = 8'd0;
                    dut_in_s         = idx_to_vec({N_IN{1'b0}});
                    err_cnt_s        = {(N_IN+1){1'b0}};
                    first_fail_s     = {N_IN{1'b0}};
                    first_fail_vld_s = 1'b0;
                    pass_s           = 1'b0;
                    busy_s           = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s  = ST_IDLE;
                    idx_s    = {N_IN{1'b0}};
                    cnt_s    = 8'd0;
                    dut_in_s = {N_IN{1'b0}};
                    pass_s   = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_SAMPLE;
                    busy_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r + 8'd1;
                    busy_s = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    // Abort discards this cycle's sample entirely.
                    state_s  = ST_IDLE;
                    idx_s    = {N_IN{1'b0}};
                    cnt_s    = 8'd0;
                    dut_in_s = {N_IN{1'b0}};
                    pass_s   = 1'b0;
                end else begin
                    if (mismatch_s) begin
                        err_cnt_s = err_cnt_r + (N_IN+1)'(1);
                        if (!first_fail_vld_r) begin
                            first_fail_s     = dut_in_r;
                            first_fail_vld_s = 1'b1;
                        end else begin
                            first_fail_s     = first_fail_r;
                        end
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        pass_s  = (err_cnt_s == {(N_IN+1){1'b0}});
                    end else begin
                        state_s  = ST_SETTLE;
                        idx_s    = idx_r + N_IN'(1);
                        dut_in_s = idx_to_vec(idx_r + N_IN'(1));
                        cnt_s    = 8'd0;
                        busy_s   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            idx_r            <= {N_IN{1'b0}};
            cnt_r            <= 8'd0;
            dut_in_r         <= {N_IN{1'b0}};
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_cnt_r        <= {(N_IN+1){1'b0}};
            first_fail_r     <= {N_IN{1'b0}};
            first_fail_vld_r <= 1'b0;
        end else begin
            state_r          <= state_s;
            idx_r            <= idx_s;
            cnt_r            <= cnt_s;
            dut_in_r         <= dut_in_s;
            busy_r           <= busy_s;
            done_r           <= done_s;
            pass_r           <= pass_s;
            err_cnt_r        <= err_cnt_s;
            first_fail_r     <= first_fail_s;
            first_fail_vld_r <= first_fail_vld_s;
        end
    end

    assign dut_in         = dut_in_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_fail     = first_fail_r;
    assign first_fail_vld = first_fail_vld_r;

endmodule

// File: tb/tb_exhaustive_sweep_ctrl.sv
// Self-checking bench for exhaustive_sweep_ctrl: directed table, random truth tables/aborts, start-hold and reset cases.
module tb_exhaustive_sweep_ctrl;

    localparam logic [7:0] EXP      = 8'hE8;
    localparam int         SPV      = 3;
    localparam int         NV       = 8;
    localparam int         DONE_CYC = NV * SPV + 1;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, dut_out;
    logic [2:0] dut_in, first_fail;
    logic [3:0] err_cnt;
    logic       busy, done, pass, first_fail_vld;
    logic [7:0] tt_r;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] tt;
        int         ab;
        int         e_err;
        int         e_ff;
        int         e_vld;
        int         e_pass;
    } vec_t;

    vec_t tbl [6];

    exhaustive_sweep_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_out        (dut_out),
        .dut_in         (dut_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    always #5 clk = ~clk;

    // Behavioural unit under test: a lookup of the current truth table.
    assign dut_out = tt_r[dut_in];

    function automatic logic [2:0] vec_at(input int k);
        logic [2:0] b;
        b = 3'(k);
`ifdef SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Reference: vector k is scored at cycle SPV*(k+1); an abort in cycle ab suppresses that sample and later ones.
    task automatic model(input logic [7:0] tt, input int ab,
                         output int err, output int ff, output int vld, output int ps);
        logic [2:0] v;
        err = 0; ff = 0; vld = 0;
        for (int k = 0; k < NV; k++) begin
            if (ab == 0 || SPV * (k + 1) < ab) begin
                v = vec_at(k);
                if (tt[v] != EXP[v]) begin
                    err++;
                    if (vld == 0) begin
                        ff  = int'(v);
                        vld = 1;
                    end
                end
            end
        end
        ps = (ab == 0 && err == 0) ? 1 : 0;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_sweep(input logic [7:0] tt, input int ab, input logic hold,
                             input int e_err, input int e_ff, input int e_vld, input int e_pass);
        logic gone;
        tt_r  = tt;
        abort = 1'b0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int n = 1; n <= DONE_CYC + 1; n++) begin
            abort = (n == ab);
            gone  = (ab != 0 && n > ab);
            check("busy", 32'(busy), (n < DONE_CYC && !gone) ? 1 : 0);
            check("done", 32'(done), (n == DONE_CYC && ab == 0) ? 1 : 0);
            if (n < DONE_CYC)
                check("dut_in", 32'(dut_in), gone ? 0 : int'(vec_at((n - 1) / SPV)));
            if (gone) check("pass_after_abort", 32'(pass), 0);
            if (n == DONE_CYC + 1) begin
                check("err_cnt", 32'(err_cnt), e_err);
                check("first_fail_vld", 32'(first_fail_vld), e_vld);
                if (e_vld != 0) check("first_fail", 32'(first_fail), e_ff);
                check("pass", 32'(pass), e_pass);
            end
            tick();
        end
        abort = 1'b0;
    endtask

    initial begin
        int e_err, e_ff, e_vld, e_pass, ab;
        logic [7:0] rt;

        tbl[0] = '{8'hE8, 0,  0, 0, 0, 1};
        tbl[1] = '{8'h00, 0,  4, 3, 1, 0};
        tbl[2] = '{8'hFF, 0,  4, 0, 1, 0};
        tbl[3] = '{8'h17, 0,  8, 0, 1, 0};
        tbl[4] = '{8'hE8, 14, 0, 0, 0, 0};
        tbl[5] = '{8'hFF, 7,  2, 0, 1, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tt_r = EXP;
        repeat (3) @(negedge clk);
        check("rst_dut_in", 32'(dut_in), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_first_fail", 32'(first_fail), 0);
        check("rst_first_fail_vld", 32'(first_fail_vld), 0);
        rst_n = 1'b1;
        tick();

        // start together with abort in IDLE must not launch a sweep
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", 32'(busy), 0);
        tick();

        for (int i = 0; i < 6; i++)
            run_sweep(tbl[i].tt, tbl[i].ab, 1'b0, tbl[i].e_err, tbl[i].e_ff, tbl[i].e_vld, tbl[i].e_pass);

        // abort then restart completes cleanly
        run_sweep(EXP, 0, 1'b0, 0, 0, 0, 1);

        for (int i = 0; i < 24; i++) begin
            rt = 8'($urandom);
            ab = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, DONE_CYC - 1)) : 0;
            model(rt, ab, e_err, e_ff, e_vld, e_pass);
            run_sweep(rt, ab, 1'b0, e_err, e_ff, e_vld, e_pass);
        end

        // start held high: one done, then a fresh sweep from IDLE with cleared score
        run_sweep(8'h00, 0, 1'b1, 4, 3, 1, 0);
        check("hold_busy_again", 32'(busy), 1);
        check("hold_err_cleared", 32'(err_cnt), 0);
        check("hold_vld_cleared", 32'(first_fail_vld), 0);
        check("hold_dut_in", 32'(dut_in), 0);
        start = 1'b0;
        for (int i = 0; i < 60 && !done; i++) tick();
        check("hold_second_done", 32'(done), 1);
        check("hold_second_err", 32'(err_cnt), 4);
        tick();
        tick();

        // asynchronous reset in the middle of SETTLE
        tt_r = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_err_cnt", 32'(err_cnt), 1);
        check("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dut_in", 32'(dut_in), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_err_cnt", 32'(err_cnt), 0);
        check("arst_first_fail_vld", 32'(first_fail_vld), 0);
        check("arst_first_fail", 32'(first_fail), 0);
        check("arst_pass", 32'(pass), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_done", 32'(done), 0);
            check("post_rst_dut_in", 32'(dut_in), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
